// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: turns single read/write commands into AHB-Lite SINGLE word
// transfers, with one transfer outstanding and a bounded data-phase wait.
//
// Ports
//   HCLK, HRESETn            clock, synchronous active-low reset
//   cmd_valid/cmd_ready      command handshake (cmd_write, cmd_addr, cmd_wdata)
//   rsp_valid                one-cycle response pulse, no backpressure
//   rsp_rdata/rsp_err/rsp_timeout  response payload, valid with rsp_valid
//   HADDR..HWDATA            AHB master outputs (HSIZE/HBURST constant)
//   HRDATA, HREADY, HRESP    AHB slave-side inputs
module ahb_cmd_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_q,  wait_d;
    logic [31:0]        haddr_d, hwdata_d, rdata_d;
    logic [1:0]         htrans_d;
    logic               hwrite_d, rvalid_d, rerr_d, rtmo_d;

    assign HSIZE  = 3'b010;
    assign HBURST = 3'b000;

    // Ready only while idle and out of reset; depends on HRESETn so it drops during reset.
    assign cmd_ready = (state_q == ST_IDLE) && HRESETn;

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        haddr_d  = HADDR;
        hwdata_d = HWDATA;
        hwrite_d = HWRITE;
        htrans_d = HTRANS;
        rvalid_d = 1'b0;
        rdata_d  = rsp_rdata;
        rerr_d   = rsp_err;
        rtmo_d   = rsp_timeout;

        case (state_q)
            ST_IDLE: begin
                htrans_d = TRANS_IDLE;
                if (cmd_valid) begin
                    state_d  = ST_ADDR;
                    haddr_d  = cmd_addr & 32'hFFFF_FFFC;
                    hwrite_d = cmd_write;
                    hwdata_d = cmd_wdata;
                    htrans_d = TRANS_NONSEQ;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_d  = ST_DATA;
                    htrans_d = TRANS_IDLE;
                    wait_d   = '0;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    state_d  = ST_IDLE;
                    rvalid_d = 1'b1;
                    rerr_d   = HRESP;
                    rtmo_d   = 1'b0;
                    rdata_d  = HWRITE ? 32'h0 : HRDATA;
                end else if (wait_q >= CNT_W'(TIMEOUT - 1)) begin
                    // This low cycle brings the count to TIMEOUT: abandon the transfer.
                    state_d  = ST_IDLE;
                    wait_d   = CNT_W'(TIMEOUT);
                    rvalid_d = 1'b1;
                    rerr_d   = 1'b1;
                    rtmo_d   = 1'b1;
                    rdata_d  = 32'h0;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                htrans_d = TRANS_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            HADDR       <= 32'h0;
            HWDATA      <= 32'h0;
            HWRITE      <= 1'b0;
            HTRANS      <= TRANS_IDLE;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'h0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            HADDR       <= haddr_d;
            HWDATA      <= hwdata_d;
            HWRITE      <= hwrite_d;
            HTRANS      <= htrans_d;
            rsp_valid   <= rvalid_d;
            rsp_rdata   <= rdata_d;
            rsp_err     <= rerr_d;
            rsp_timeout <= rtmo_d;
        end
    end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master: the bench plays the AHB slave and the
// command source; all values are sampled 1 time unit after the rising edge.
module tb_ahb_cmd_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;

    int n_cmp = 0;
    int n_bad = 0;

    ahb_cmd_master #(.TIMEOUT(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Present a command; the caller ticks to have it accepted.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
    endtask

    int pulses;

    initial begin
        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = 32'h0; cmd_wdata = 32'h0;
        HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_ready",  32'(cmd_ready), 32'd0);
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr",  HADDR, 32'h0);
        chk("rst_rvalid", 32'(rsp_valid), 32'd0);
        chk("hsize",      32'(HSIZE), 32'd2);
        chk("hburst",     32'(HBURST), 32'd0);
        HRESETn = 1'b1;
        #1;
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Zero-wait write
        issue(1'b1, 32'h5300_0004, 32'h0000_0001);
        tick();
        cmd_valid = 1'b0;
        chk("w_haddr",  HADDR, 32'h5300_0004);
        chk("w_htrans", 32'(HTRANS), 32'd2);
        chk("w_hwrite", 32'(HWRITE), 32'd1);
        chk("w_ready",  32'(cmd_ready), 32'd0);
        tick();
        chk("w_htrans_data", 32'(HTRANS), 32'd0);
        chk("w_hwdata", HWDATA, 32'h0000_0001);
        chk("w_rvalid0", 32'(rsp_valid), 32'd0);
        tick();
        chk("w_rvalid", 32'(rsp_valid), 32'd1);
        chk("w_rerr",   32'(rsp_err), 32'd0);
        chk("w_rtmo",   32'(rsp_timeout), 32'd0);
        chk("w_rdata",  rsp_rdata, 32'h0);
        chk("w_ready_back", 32'(cmd_ready), 32'd1);
        tick();
        chk("w_rvalid_pulse", 32'(rsp_valid), 32'd0);

        // Read with 3 wait states; cmd inputs change mid-transfer
        HRDATA = 32'h0000_A5A5;
        issue(1'b0, 32'h5300_0000, 32'h1234_5678);
        tick();
        cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF; cmd_write = 1'b1; cmd_wdata = 32'hFFFF_FFFF;
        chk("r_haddr",  HADDR, 32'h5300_0000);
        chk("r_hwrite", 32'(HWRITE), 32'd0);
        tick();
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r_wait_haddr",  HADDR, 32'h5300_0000);
            chk("r_wait_hwdata", HWDATA, 32'h1234_5678);
            chk("r_wait_htrans", 32'(HTRANS), 32'd0);
            chk("r_wait_rvalid", 32'(rsp_valid), 32'd0);
        end
        HREADY = 1'b1;
        tick();
        chk("r_rvalid", 32'(rsp_valid), 32'd1);
        chk("r_rdata",  rsp_rdata, 32'h0000_A5A5);
        chk("r_rerr",   32'(rsp_err), 32'd0);
        tick();

        // Two-cycle ERROR response on a write
        issue(1'b1, 32'h5300_0008, 32'hDEAD_BEEF);
        tick();
        cmd_valid = 1'b0;
        tick();
        HREADY = 1'b0; HRESP = 1'b1;
        tick();
        chk("e_rvalid0", 32'(rsp_valid), 32'd0);
        HREADY = 1'b1;
        tick();
        HRESP = 1'b0;
        chk("e_rvalid", 32'(rsp_valid), 32'd1);
        chk("e_rerr",   32'(rsp_err), 32'd1);
        chk("e_rtmo",   32'(rsp_timeout), 32'd0);
        tick();

        // Timeout on a read: HREADY held low for 16 data cycles
        HRDATA = 32'hCAFE_F00D;
        issue(1'b0, 32'h5300_0010, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        HREADY = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("t_wait_rvalid", 32'(rsp_valid), 32'd0);
        end
        tick();
        chk("t_rvalid", 32'(rsp_valid), 32'd1);
        chk("t_rerr",   32'(rsp_err), 32'd1);
        chk("t_rtmo",   32'(rsp_timeout), 32'd1);
        chk("t_rdata",  rsp_rdata, 32'h0);
        chk("t_ready",  32'(cmd_ready), 32'd1);
        HREADY = 1'b1;
        tick();
        chk("t_rvalid_pulse", 32'(rsp_valid), 32'd0);

        // Reset for one edge in the middle of a DATA phase
        issue(1'b1, 32'h5300_0020, 32'h5555_AAAA);
        tick();
        cmd_valid = 1'b0;
        tick();
        HREADY = 1'b0;
        tick();
        HRESETn = 1'b0;
        tick();
        chk("mr_htrans", 32'(HTRANS), 32'd0);
        chk("mr_rvalid", 32'(rsp_valid), 32'd0);
        chk("mr_haddr",  HADDR, 32'h0);
        chk("mr_ready_in_rst", 32'(cmd_ready), 32'd0);
        HRESETn = 1'b1; HREADY = 1'b1;
        #1;
        chk("mr_ready", 32'(cmd_ready), 32'd1);
        tick();
        chk("mr_no_rsp", 32'(rsp_valid), 32'd0);

        // Back-to-back zero-wait reads with cmd_valid held high
        HRDATA = 32'h0000_0042;
        issue(1'b0, 32'h5300_0003, 32'h0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 9) cmd_valid = 1'b0;
            if (i == 0) chk("b_haddr_align", HADDR, 32'h5300_0000);
            chk("b_rvalid", 32'(rsp_valid), (i % 3 == 2) ? 32'd1 : 32'd0);
            if (rsp_valid) pulses++;
        end
        chk("b_pulses", 32'(pulses), 32'd4);
        tick();
        chk("b_idle_after", 32'(rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of HREADY-low data-phase cycles before the transfer is abandoned.
REQ-002 HCLK  in  1  single clock; all state SHALL change on the rising edge only.
REQ-003 HRESETn  in  1  reset, synchronous and active-low (sampled on the HCLK rising edge).
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accept.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  32  byte address.
REQ-008 cmd_wdata  in  32  write data.
REQ-009 rsp_valid  out  1  one-cycle response pulse.
REQ-010 rsp_rdata  out  32  read data, valid with rsp_valid.
REQ-011 rsp_err  out  1  error or timeout, valid with rsp_valid.
REQ-012 rsp_timeout  out  1  timeout indication, valid with rsp_valid.
REQ-013 HADDR  out  32  AHB address.
REQ-014 HTRANS  out  2  AHB transfer type.
REQ-015 HWRITE  out  1  AHB direction.
REQ-016 HSIZE  out  3  AHB size; constant 3'b010.
REQ-017 HBURST  out  3  AHB burst; constant 3'b000 (SINGLE).
REQ-018 HWDATA  out  32  AHB write data.
REQ-019 HRDATA  in  32  AHB read data.
REQ-020 HREADY  in  1  AHB bus ready, taken from the slave mux.
REQ-021 HRESP  in  1  AHB response; 1 = ERROR.

Function
REQ-022 The block SHALL implement a three-state FSM with states IDLE, ADDR and DATA, and SHALL have at most one transfer outstanding.
REQ-023 cmd_ready SHALL be 1 only in IDLE with reset deasserted; a command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1, and the FSM SHALL then go IDLE->ADDR.
REQ-024 On acceptance the block SHALL register the following, all held stable until the transfer ends:
- HADDR = {cmd_addr[31:2], 2'b00}
- HWRITE = cmd_write
- wdata = cmd_wdata
REQ-025 In ADDR, HTRANS SHALL be 2'b10 (NONSEQ); the FSM SHALL stay in ADDR while HREADY=0 and go ADDR->DATA on the first edge where HREADY=1.
REQ-026 In IDLE and DATA, HTRANS SHALL be 2'b00; in DATA, HWDATA SHALL equal the latched wdata for every cycle, including wait states.
REQ-027 A wait counter SHALL clear on entry to DATA and increment on each DATA-state edge where HREADY=0; it SHALL saturate at TIMEOUT and never wrap.
REQ-028 On a DATA-state edge where HREADY=1, the FSM SHALL go DATA->IDLE and the block SHALL register:
- rsp_valid = 1
- rsp_err = HRESP
- rsp_timeout = 0
- rsp_rdata = HRDATA for reads, 0 for writes
REQ-029 If the wait counter reaches TIMEOUT while HREADY is still 0, the FSM SHALL go DATA->IDLE with rsp_valid=1, rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-030 rsp_valid SHALL be high for exactly one cycle per accepted command, in the cycle after completion, and SHALL have no backpressure.
REQ-031 A two-cycle ERROR response (HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1) SHALL be sampled only on the HREADY=1 edge, giving rsp_err=1.
REQ-032 cmd_ready SHALL reassert in the cycle rsp_valid is high, giving a minimum of 3 cycles per command with zero wait states.
REQ-033 cmd_* inputs SHALL be ignored outside IDLE; changes to them during a transfer SHALL NOT alter any AHB output.

Reset
REQ-034 When HRESETn=0 at a rising edge, the block SHALL force the following, abandoning any transfer in progress without a response:
- FSM = IDLE
- HADDR, HWDATA, rsp_rdata = 0
- HTRANS = 2'b00
- HWRITE, rsp_valid, rsp_err, rsp_timeout = 0
- wait counter = 0
REQ-035 cmd_ready SHALL be 0 while HRESETn=0 and SHALL be 1 in the first cycle after reset is released.
REQ-036 HSIZE and HBURST SHALL be constant regardless of reset.

Verification
REQ-037 Write 0x53000004 <- 0x00000001, zero wait states -> HADDR=0x53000004 with HTRANS=10 and HWRITE=1 for 1 cycle; next cycle HWDATA=0x00000001; rsp_valid one cycle later with rsp_err=0.
REQ-038 Read 0x53000000 with HRDATA=0x0000A5A5 and 3 HREADY-low data cycles -> HWDATA/HADDR stable throughout; rsp_rdata=0x0000A5A5, rsp_err=0.
REQ-039 Write with HRESP=1/HREADY=0 then HRESP=1/HREADY=1 -> rsp_valid with rsp_err=1 and rsp_timeout=0.
REQ-040 Read with HREADY held at 0 in the data phase, TIMEOUT=16 -> rsp_valid after 16 wait cycles with rsp_err=1, rsp_timeout=1, rsp_rdata=0, then cmd_ready=1.
REQ-041 HRESETn=0 for one edge in the middle of a DATA phase -> next cycle HTRANS=00, no rsp_valid, cmd_ready=1 once reset is released.
REQ-042 cmd_valid held at 1 for 4 zero-wait commands -> 4 rsp_valid pulses, one every 3 cycles; cmd_addr 0x53000003 drives HADDR=0x53000000.
